bellman_ford_relax: RTL and testbench

//  Writer side of the vertex matrix: runs Bellman-Ford relaxation over the adjacency matrix and writes each

---
 rtl/hft_pkg.sv | 38 +++
 rtl/relax_alu.sv | 38 +++
 rtl/bellman_ford_relax.sv | 186 ++++++++++++++++++
 tb/tb_bellman_ford_relax.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Shared types and default sizing for the arbitrage graph engines (relaxation writer, cycle detector).
// Vertex words are {valid, pred, weight}; weights are signed log-rates and a zero edge means "no edge".
package hft_pkg;

    localparam int DEF_NODES    = 4;
    localparam int PRED_WIDTH   = 1;
    localparam int WEIGHT_WIDTH = 7;
    localparam int VERT_WIDTH   = 10;

    localparam int DEF_PW = PRED_WIDTH + 1;
    localparam int DEF_WW = WEIGHT_WIDTH + 1;
    localparam int DEF_VW = VERT_WIDTH + 1;

    typedef struct packed {
        logic              valid;
        logic [DEF_PW-1:0] pred;
        logic [DEF_WW-1:0] weight;
    } vert_word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_RELAX = 3'd3,
        ST_DONE  = 3'd4
    } relax_state_t;

    function automatic vert_word_t make_vert(input logic              valid,
                                             input logic [DEF_PW-1:0] pred,
                                             input logic [DEF_WW-1:0] weight);
        vert_word_t w;
        w.valid  = valid;
        w.pred   = pred;
        w.weight = weight;
        return w;
    endfunction

endpackage

// File: rtl/relax_alu.sv
// Relaxation decision for one edge: candidate distance, range check and improvement test.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is consumed.
module relax_alu
    import hft_pkg::*;
#(
    parameter int WW = DEF_WW
) (
    input  logic          edge_ok_i,
    input  logic          src_valid_i,
    input  logic [WW-1:0] src_weight_i,
    input  logic          dst_valid_i,
    input  logic [WW-1:0] dst_weight_i,
    input  logic [WW-1:0] edge_weight_i,
    output logic [WW-1:0] cand_o,
    output logic          update_o,
    output logic          ovf_o
);

    logic signed [WW:0] sum;
    logic               fits;
    logic               better;
    logic               active;

    always_comb begin
        sum    = $signed({src_weight_i[WW-1], src_weight_i})
               + $signed({edge_weight_i[WW-1], edge_weight_i});
        // The extra top bit disagrees with the WW-bit sign exactly when the sum left the range.
        fits   = (sum[WW] == sum[WW-1]);
        better = !dst_valid_i || ($signed(sum[WW-1:0]) < $signed(dst_weight_i));
        active = edge_ok_i && src_valid_i;

        cand_o   = sum[WW-1:0];
        update_o = active && fits && better;
        ovf_o    = active && !fits;
    end

endmodule

// File: rtl/bellman_ford_relax.sv
// Bellman-Ford relaxation over the adjacency matrix, writing {valid, pred, weight} words into vertmat.
// Latency: NODES init cycles plus 2*NODES^2 cycles per pass, at most NODES-1 passes.
// Backpressure: none; relax_start is ignored while busy, relax_done holds until the next start.
module bellman_ford_relax
    import hft_pkg::*;
#(
    parameter int NODES = DEF_NODES,
    parameter int PW    = DEF_PW,
    parameter int WW    = DEF_WW,
    parameter int VW    = DEF_VW
) (
    input  logic          clk,
    input  logic          relax_reset_n,
    input  logic          relax_start,
    input  logic [PW-1:0] src_vert,
    input  logic [WW-1:0] adjmat_q,
    input  logic [VW-1:0] vertmat_q_a,
    input  logic [VW-1:0] vertmat_q_b,
    output logic [PW-1:0] adjmat_row_addr,
    output logic [PW-1:0] adjmat_col_addr,
    output logic [PW-1:0] vertmat_addr_a,
    output logic [PW-1:0] vertmat_addr_b,
    output logic [VW-1:0] vertmat_data_b,
    output logic          vertmat_we_b,
    output logic          relax_busy,
    output logic          relax_done,
    output logic [PW-1:0] pass_count,
    output logic          overflow
);

    localparam logic [PW-1:0] LAST = PW'(NODES - 1);

    relax_state_t  state_q, state_d;
    logic [PW-1:0] i_q, i_d;
    logic [PW-1:0] j_q, j_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [PW-1:0] src_q, src_d;
    logic          dirty_q, dirty_d;
    logic          ovf_q, ovf_d;

    logic [WW-1:0] alu_cand;
    logic          alu_update;
    logic          alu_ovf;
    logic          relax_wr;
    logic          pass_dirty;
    logic [PW-1:0] pass_next;

    // Predecessor fields of the read words play no part in relaxation.
    logic unused_pred;
    assign unused_pred = ^{vertmat_q_a[VW-2:WW], vertmat_q_b[VW-2:WW]};

    relax_alu #(
        .WW(WW)
    ) u_alu (
        .edge_ok_i    ((adjmat_q != '0) && (i_q != j_q)),
        .src_valid_i  (vertmat_q_a[VW-1]),
        .src_weight_i (vertmat_q_a[WW-1:0]),
        .dst_valid_i  (vertmat_q_b[VW-1]),
        .dst_weight_i (vertmat_q_b[WW-1:0]),
        .edge_weight_i(adjmat_q),
        .cand_o       (alu_cand),
        .update_o     (alu_update),
        .ovf_o        (alu_ovf)
    );

    assign relax_wr   = (state_q == ST_RELAX) && alu_update;
    assign pass_dirty = dirty_q || relax_wr;
    assign pass_next  = pass_q + PW'(1);

    always_ff @(posedge clk or negedge relax_reset_n) begin
        if (!relax_reset_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            pass_q  <= '0;
            src_q   <= '0;
            dirty_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            pass_q  <= pass_d;
            src_q   <= src_d;
            dirty_q <= dirty_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        pass_d  = pass_q;
        src_d   = src_q;
        dirty_d = dirty_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (relax_start) begin
                    state_d = ST_INIT;
                    i_d     = '0;
                    j_d     = '0;
                    pass_d  = '0;
                    src_d   = src_vert;
                    dirty_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            ST_INIT: begin
                // j doubles as the init index so addr_b walks every vertex once.
                if (j_q == LAST) begin
                    state_d = ST_READ;
                    i_d     = '0;
                    j_d     = '0;
                end else begin
                    j_d = j_q + PW'(1);
                end
            end
            ST_READ: begin
                state_d = ST_RELAX;
            end
            ST_RELAX: begin
                dirty_d = pass_dirty;
                ovf_d   = ovf_q || alu_ovf;
                state_d = ST_READ;
                if (j_q != LAST) begin
                    j_d = j_q + PW'(1);
                end else begin
                    j_d = '0;
                    if (i_q != LAST) begin
                        i_d = i_q + PW'(1);
                    end else begin
                        i_d     = '0;
                        pass_d  = pass_next;
                        dirty_d = 1'b0;
                        if (!pass_dirty || (pass_next == LAST)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        relax_busy     = 1'b0;
        relax_done     = 1'b0;
        vertmat_we_b   = 1'b0;
        vertmat_data_b = '0;
        unique case (state_q)
            ST_INIT: begin
                relax_busy     = 1'b1;
                vertmat_we_b   = 1'b1;
                vertmat_data_b = {(j_q == src_q), j_q, {WW{1'b0}}};
            end
            ST_READ: begin
                relax_busy = 1'b1;
            end
            ST_RELAX: begin
                relax_busy = 1'b1;
                if (relax_wr) begin
                    vertmat_we_b   = 1'b1;
                    vertmat_data_b = {1'b1, i_q, alu_cand};
                end
            end
            ST_DONE: begin
                relax_done = 1'b1;
            end
            default: begin
                relax_busy = 1'b0;
            end
        endcase
    end

    assign adjmat_row_addr = i_q;
    assign adjmat_col_addr = j_q;
    assign vertmat_addr_a  = i_q;
    assign vertmat_addr_b  = j_q;
    assign pass_count      = pass_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_bellman_ford_relax.sv
// Randomized bench for bellman_ford_relax against a plain Gauss-Seidel Bellman-Ford model.
// Directed cases pin the model with hand-computed vertex words and pass counts.
module tb_bellman_ford_relax;
    import hft_pkg::*;

    localparam int N    = DEF_NODES;
    localparam int PW   = DEF_PW;
    localparam int WW   = DEF_WW;
    localparam int VW   = DEF_VW;
    localparam int WMAX = (1 << (WW - 1)) - 1;
    localparam int WMIN = -(1 << (WW - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          relax_start = 1'b0;
    logic [PW-1:0] src_vert = '0;
    logic [WW-1:0] adjmat_q;
    logic [VW-1:0] vertmat_q_a;
    logic [VW-1:0] vertmat_q_b;
    logic [PW-1:0] adjmat_row_addr;
    logic [PW-1:0] adjmat_col_addr;
    logic [PW-1:0] vertmat_addr_a;
    logic [PW-1:0] vertmat_addr_b;
    logic [VW-1:0] vertmat_data_b;
    logic          vertmat_we_b;
    logic          relax_busy;
    logic          relax_done;
    logic [PW-1:0] pass_count;
    logic          overflow;

    bellman_ford_relax dut (
        .clk            (clk),
        .relax_reset_n  (rst_n),
        .relax_start    (relax_start),
        .src_vert       (src_vert),
        .adjmat_q       (adjmat_q),
        .vertmat_q_a    (vertmat_q_a),
        .vertmat_q_b    (vertmat_q_b),
        .adjmat_row_addr(adjmat_row_addr),
        .adjmat_col_addr(adjmat_col_addr),
        .vertmat_addr_a (vertmat_addr_a),
        .vertmat_addr_b (vertmat_addr_b),
        .vertmat_data_b (vertmat_data_b),
        .vertmat_we_b   (vertmat_we_b),
        .relax_busy     (relax_busy),
        .relax_done     (relax_done),
        .pass_count     (pass_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous RAMs
    logic signed [WW-1:0] adj [N][N];
    logic [VW-1:0]        vmem [N];

    always @(posedge clk) begin
        adjmat_q    <= adj[adjmat_row_addr][adjmat_col_addr];
        vertmat_q_a <= vmem[vertmat_addr_a];
        vertmat_q_b <= vmem[vertmat_addr_b];
        if (vertmat_we_b) vmem[vertmat_addr_b] <= vertmat_data_b;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s", nm);
    endtask

    // Behavioural model: ordered list of expected writes plus final distances.
    typedef struct {
        int            addr;
        logic [VW-1:0] data;
    } wr_t;

    wr_t exp_wq [$];
    wr_t cw;
    int  m_valid [N];
    int  m_pred  [N];
    int  m_w     [N];
    int  m_pass;
    int  m_ovf;

    function automatic logic [VW-1:0] mword(input int k);
        return make_vert(m_valid[k] != 0, PW'(m_pred[k]), WW'(m_w[k]));
    endfunction

    task automatic model_run(input int src);
        bit dirty;
        int s;
        exp_wq.delete();
        for (int k = 0; k < N; k++) begin
            m_valid[k] = (k == src) ? 1 : 0;
            m_pred[k]  = k;
            m_w[k]     = 0;
            exp_wq.push_back('{k, mword(k)});
        end
        m_ovf  = 0;
        m_pass = 0;
        do begin
            dirty = 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (adj[i][j] != 0 && i != j && m_valid[i] != 0) begin
                        s = m_w[i] + int'(adj[i][j]);
                        if (s > WMAX || s < WMIN) begin
                            m_ovf = 1;
                        end else if (m_valid[j] == 0 || s < m_w[j]) begin
                            m_valid[j] = 1;
                            m_pred[j]  = i;
                            m_w[j]     = s;
                            exp_wq.push_back('{j, mword(j)});
                            dirty = 1'b1;
                        end
                    end
                end
            end
            m_pass++;
        end while (dirty && m_pass < N - 1);
    endtask

    // Every DUT write must be the next one the model predicts.
    always @(negedge clk) begin
        if (rst_n && vertmat_we_b) begin
            if (exp_wq.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                cw = exp_wq.pop_front();
                chk("wr_addr", 32'(vertmat_addr_b), 32'(cw.addr));
                chk("wr_data", 32'(vertmat_data_b), 32'(cw.data));
            end
        end
    end

    task automatic clear_adj();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                adj[i][j] = '0;
    endtask

    task automatic start_pulse(input int src);
        @(negedge clk);
        relax_start = 1'b1;
        src_vert    = PW'(src);
        @(negedge clk);
        relax_start = 1'b0;
        src_vert    = PW'(src + 1);
        chk("done_drop", 32'(relax_done), 32'd0);
        chk("busy_rise", 32'(relax_busy), 32'd1);
    endtask

    task automatic run_case(input int src, input bit poke, output int busy_cyc);
        bit fin;
        model_run(src);
        start_pulse(src);
        busy_cyc = 0;
        fin      = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (relax_done) begin
                fin = 1'b1;
            end else begin
                if (relax_busy) busy_cyc++;
                relax_start = (poke && busy_cyc == 20);
                @(negedge clk);
            end
        end
        relax_start = 1'b0;
        if (!fin) fail_now("run_timeout");
        chk("end_done", 32'(relax_done), 32'd1);
        chk("end_busy", 32'(relax_busy), 32'd0);
        chk("end_pass", 32'(pass_count), 32'(m_pass));
        chk("end_ovf", 32'(overflow), 32'(m_ovf));
        chk("end_cycles", 32'(busy_cyc), 32'(N + 2 * N * N * m_pass));
        for (int k = 0; k < N; k++) chk("end_vert", 32'(vmem[k]), 32'(mword(k)));
        chk("writes_left", 32'(exp_wq.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int bc;
        int bad;
        bit hit;
        logic [VW-1:0] snap [N];

        clear_adj();
        for (int k = 0; k < N; k++) vmem[k] = '0;

        #2;
        chk("rst_we", 32'(vertmat_we_b), 32'd0);
        chk("rst_busy_done", 32'({relax_busy, relax_done}), 32'd0);
        chk("rst_pass_ovf", 32'({pass_count, overflow}), 32'd0);
        chk("rst_addr", 32'({adjmat_row_addr, adjmat_col_addr, vertmat_addr_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Chain 0->1 w=5, 1->2 w=-3
        clear_adj();
        adj[0][1] = 8'sd5;
        adj[1][2] = -8'sd3;
        run_case(0, 1'b0, bc);
        chk("chain_model_pass", 32'(m_pass), 32'd2);
        chk("chain_v1", 32'(vmem[1]), 32'(make_vert(1'b1, 2'd0, 8'd5)));
        chk("chain_v2", 32'(vmem[2]), 32'(make_vert(1'b1, 2'd1, 8'd2)));
        chk("chain_v3_valid", 32'(vmem[3][VW-1]), 32'd0);
        chk("chain_pass", 32'(pass_count), 32'd2);

        // Empty graph, src=2
        clear_adj();
        run_case(2, 1'b0, bc);
        chk("empty_cycles", 32'(bc), 32'd36);
        chk("empty_pass", 32'(pass_count), 32'd1);
        chk("empty_v2", 32'(vmem[2]), 32'(make_vert(1'b1, 2'd2, 8'd0)));
        chk("empty_v0", 32'(vmem[0]), 32'(make_vert(1'b0, 2'd0, 8'd0)));

        // Negative cycle 1<->2
        clear_adj();
        adj[0][1] = 8'sd1;
        adj[1][2] = -8'sd2;
        adj[2][1] = -8'sd2;
        run_case(0, 1'b0, bc);
        chk("negcyc_pass", 32'(pass_count), 32'd3);
        chk("negcyc_v1", 32'(vmem[1]), 32'(make_vert(1'b1, 2'd2, 8'hF5)));
        chk("negcyc_v2", 32'(vmem[2]), 32'(make_vert(1'b1, 2'd1, 8'hF7)));

        // Overflow 0->1 w=100, 1->2 w=100
        clear_adj();
        adj[0][1] = 8'sd100;
        adj[1][2] = 8'sd100;
        run_case(0, 1'b0, bc);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_v1", 32'(vmem[1]), 32'(make_vert(1'b1, 2'd0, 8'd100)));
        chk("ovf_v2_valid", 32'(vmem[2][VW-1]), 32'd0);

        // Start pulsed mid-pass is ignored; a rerun after done is identical
        clear_adj();
        adj[0][1] = 8'sd5;
        adj[1][2] = -8'sd3;
        adj[3][0] = 8'sd7;
        run_case(0, 1'b1, bc);
        for (int k = 0; k < N; k++) snap[k] = vmem[k];
        run_case(0, 1'b0, bc);
        for (int k = 0; k < N; k++) chk("rerun_same", 32'(vmem[k]), 32'(snap[k]));

        // Randomized graphs
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if ($urandom_range(0, 2) == 0) adj[i][j] = '0;
                    else if (r % 5 == 4) adj[i][j] = WW'($urandom_range(0, 255));
                    else adj[i][j] = WW'(int'($urandom_range(0, 50)) - 20);
                end
            end
            run_case(int'($urandom_range(0, N - 1)), (r % 3 == 0), bc);
        end

        // Async reset while a relaxation write is on the bus
        clear_adj();
        adj[0][1] = 8'sd5;
        adj[1][2] = -8'sd3;
        model_run(0);
        start_pulse(0);
        hit = 1'b0;
        bc  = 1;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            @(negedge clk);
            if (relax_busy) bc++;
            if (vertmat_we_b && bc > N) hit = 1'b1;
        end
        if (!hit) fail_now("reset_wait_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(vertmat_we_b), 32'd0);
        chk("arst_data", 32'(vertmat_data_b), 32'd0);
        chk("arst_busy_done", 32'({relax_busy, relax_done}), 32'd0);
        chk("arst_pass_ovf", 32'({pass_count, overflow}), 32'd0);
        chk("arst_addr", 32'({adjmat_row_addr, adjmat_col_addr, vertmat_addr_a, vertmat_addr_b}), 32'd0);
        bad = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 5) rst_n = 1'b1;
            if (vertmat_we_b || relax_busy || relax_done) bad++;
        end
        chk("post_reset_quiet", 32'(bad), 32'd0);

        // Restart after reset still works
        run_case(0, 1'b0, bc);
        chk("post_reset_v2", 32'(vmem[2]), 32'(make_vert(1'b1, 2'd1, 8'd2)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
